// File: rtl/load_use_stall_unit_if.sv
// rtl/load_use_stall_unit_if.sv - hazard-unit signal bundle between pipeline and load_use_stall_unit
// Optional macro HAZARD_PERF_EN adds PERF_CLR, LU_STALL_COUNT and MEM_WAIT_COUNT.
// Signals:
//   REG_READ_ADDR1_S2/2_S2 - stage-2 source registers; S2_USES_RS1/RS2 - source valid
//   S2_MEM_WRITE           - stage-2 store; STAGE_3_MEM_READ/STAGE3_REG_ADDR - stage-3 load
//   DATA_MEM_BUSYWAIT      - data memory not ready
//   STALL_FRONT/BUBBLE_S3/STALL_ALL - stall controls back to the pipeline
// Modports: master = pipeline side, slave = hazard unit side.
interface load_use_stall_unit_if;
   logic [4:0]  REG_READ_ADDR1_S2;
   logic [4:0]  REG_READ_ADDR2_S2;
   logic        S2_USES_RS1;
   logic        S2_USES_RS2;
   logic        S2_MEM_WRITE;
   logic        STAGE_3_MEM_READ;
   logic [4:0]  STAGE3_REG_ADDR;
   logic        DATA_MEM_BUSYWAIT;
   logic        STALL_FRONT;
   logic        BUBBLE_S3;
   logic        STALL_ALL;
`ifdef HAZARD_PERF_EN
   logic        PERF_CLR;
   logic [15:0] LU_STALL_COUNT;
   logic [15:0] MEM_WAIT_COUNT;

   modport master (
      output REG_READ_ADDR1_S2, REG_READ_ADDR2_S2, S2_USES_RS1, S2_USES_RS2,
             S2_MEM_WRITE, STAGE_3_MEM_READ, STAGE3_REG_ADDR, DATA_MEM_BUSYWAIT, PERF_CLR,
      input  STALL_FRONT, BUBBLE_S3, STALL_ALL, LU_STALL_COUNT, MEM_WAIT_COUNT
   );
   modport slave (
      input  REG_READ_ADDR1_S2, REG_READ_ADDR2_S2, S2_USES_RS1, S2_USES_RS2,
             S2_MEM_WRITE, STAGE_3_MEM_READ, STAGE3_REG_ADDR, DATA_MEM_BUSYWAIT, PERF_CLR,
      output STALL_FRONT, BUBBLE_S3, STALL_ALL, LU_STALL_COUNT, MEM_WAIT_COUNT
   );
`else
   modport master (
      output REG_READ_ADDR1_S2, REG_READ_ADDR2_S2, S2_USES_RS1, S2_USES_RS2,
             S2_MEM_WRITE, STAGE_3_MEM_READ, STAGE3_REG_ADDR, DATA_MEM_BUSYWAIT,
      input  STALL_FRONT, BUBBLE_S3, STALL_ALL
   );
   modport slave (
      input  REG_READ_ADDR1_S2, REG_READ_ADDR2_S2, S2_USES_RS1, S2_USES_RS2,
             S2_MEM_WRITE, STAGE_3_MEM_READ, STAGE3_REG_ADDR, DATA_MEM_BUSYWAIT,
      output STALL_FRONT, BUBBLE_S3, STALL_ALL
   );
`endif
endinterface

// File: rtl/load_use_stall_unit.sv
// rtl/load_use_stall_unit.sv - load-use hazard and memory-busywait stall controller
// Optional macro HAZARD_PERF_EN adds saturating stall performance counters.
// Ports:
//   CLK   - pipeline clock
//   RESET - asynchronous active-low reset
//   hz    - load_use_stall_unit_if.slave: stage-2/3 operand info, busywait in; stall controls out
module load_use_stall_unit #(
   parameter int STALL_CYCLES = 1,
   parameter int CNT_W        = 3
) (
   input  logic                  CLK,
   input  logic                  RESET,
   load_use_stall_unit_if.slave  hz
);

   typedef enum logic [1:0] {IDLE, LU_STALL, MEM_WAIT} state_e;

   state_e             state_q, state_d;
   state_e             ret_q, ret_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   state_e             run_state, run_next;
   logic [CNT_W-1:0]   run_cnt;
   logic               run_stall;
   logic               hazard;
   logic               stall_front, bubble_s3, stall_all;

   // Store data (rs2) of a store is covered by the stage-4 forwarding path, so it never stalls.
   assign hazard = hz.STAGE_3_MEM_READ && (hz.STAGE3_REG_ADDR != 5'd0) &&
                   ((hz.S2_USES_RS1 && (hz.REG_READ_ADDR1_S2 == hz.STAGE3_REG_ADDR)) ||
                    (hz.S2_USES_RS2 && (hz.REG_READ_ADDR2_S2 == hz.STAGE3_REG_ADDR) &&
                     !hz.S2_MEM_WRITE));

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= IDLE;
         ret_q   <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      ret_d       = ret_q;
      cnt_d       = cnt_q;
      stall_front = 1'b0;
      bubble_s3   = 1'b0;
      stall_all   = 1'b0;

      // In MEM_WAIT the cycle after busywait drops behaves exactly like the parked state.
      run_state = (state_q == MEM_WAIT) ? ret_q : state_q;
      run_next  = run_state;
      run_cnt   = cnt_q;
      run_stall = 1'b0;
      case (run_state)
         LU_STALL: begin
            run_stall = 1'b1;
            run_cnt   = cnt_q - CNT_W'(1);
            run_next  = (cnt_q == CNT_W'(1)) ? IDLE : LU_STALL;
         end
         default: begin
            if (hazard) begin
               run_stall = 1'b1;
               if (STALL_CYCLES > 1) begin
                  run_next = LU_STALL;
                  run_cnt  = CNT_W'(STALL_CYCLES - 1);
               end
            end
         end
      endcase

      if (!RESET) begin
         // outputs stay at their zero defaults while reset is held
      end else if (hz.DATA_MEM_BUSYWAIT) begin
         stall_all = 1'b1;
         state_d   = MEM_WAIT;
         if (state_q != MEM_WAIT) begin
            if ((run_state == IDLE) && (run_next == LU_STALL)) begin
               // Blocked penalty entry: no bubble was issued this cycle, so arm the
               // full penalty to be served from LU_STALL once memory is ready.
               ret_d = LU_STALL;
               cnt_d = CNT_W'(STALL_CYCLES);
            end else begin
               // Nothing is consumed while frozen; park the current state and count.
               ret_d = run_state;
            end
         end
      end else begin
         stall_front = run_stall;
         bubble_s3   = run_stall;
         state_d     = run_next;
         cnt_d       = run_cnt;
         ret_d       = IDLE;
      end
   end

   assign hz.STALL_FRONT = stall_front;
   assign hz.BUBBLE_S3   = bubble_s3;
   assign hz.STALL_ALL   = stall_all;

`ifdef HAZARD_PERF_EN
   logic [15:0] lu_cnt_q, mw_cnt_q;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         lu_cnt_q <= 16'd0;
         mw_cnt_q <= 16'd0;
      end else if (hz.PERF_CLR) begin
         lu_cnt_q <= 16'd0;
         mw_cnt_q <= 16'd0;
      end else begin
         if (bubble_s3 && (lu_cnt_q != 16'hFFFF)) lu_cnt_q <= lu_cnt_q + 16'd1;
         if (stall_all && (mw_cnt_q != 16'hFFFF)) mw_cnt_q <= mw_cnt_q + 16'd1;
      end
   end

   assign hz.LU_STALL_COUNT = lu_cnt_q;
   assign hz.MEM_WAIT_COUNT = mw_cnt_q;
`endif

endmodule

// File: doc/load_use_stall_unit.md
Name: load_use_stall_unit

Overview:
- Hazard/stall controller for the 5-stage CPU pipeline.
- The stage-4 load-to-store forwarding path covers a load in stage 4 feeding store data in stage 3. This block covers every load dependency that path cannot cover.
- It detects load-use hazards between stage 2 and a load in stage 3, then holds PC and IF/ID while bubbling ID/EX for a configurable penalty.
- It freezes the whole pipeline while data memory asserts busywait.

Parameters:
STALL_CYCLES, 1, load-use penalty in cycles (legal 1..7)
CNT_W, 3, width of penalty counter; must hold STALL_CYCLES

Ports:
CLK  in  1  pipeline clock
RESET  in  1  asynchronous, active-low reset
REG_READ_ADDR1_S2  in  5  rs1 of instruction in stage 2
REG_READ_ADDR2_S2  in  5  rs2 of instruction in stage 2
S2_USES_RS1  in  1  stage-2 instruction reads rs1
S2_USES_RS2  in  1  stage-2 instruction reads rs2
S2_MEM_WRITE  in  1  stage-2 instruction is a store (rs2 = store data)
STAGE_3_MEM_READ  in  1  stage-3 instruction is a load
STAGE3_REG_ADDR  in  5  destination register of stage-3 instruction
DATA_MEM_BUSYWAIT  in  1  data memory not ready
STALL_FRONT  out  1  hold PC and IF/ID register
BUBBLE_S3  out  1  load NOP into ID/EX register
STALL_ALL  out  1  freeze every pipeline register

Behaviour:
- Hazard term H = STAGE_3_MEM_READ & (STAGE3_REG_ADDR != 0) & (M1 | M2).
  - M1 = S2_USES_RS1 & (REG_READ_ADDR1_S2 == STAGE3_REG_ADDR).
  - M2 = S2_USES_RS2 & (REG_READ_ADDR2_S2 == STAGE3_REG_ADDR) & !S2_MEM_WRITE.
  - A store whose only dependency is its data (rs2) produces no stall; the stage-4 forwarding path handles it.
  - A store whose address (rs1) depends on the load does stall.
- States: IDLE, LU_STALL, MEM_WAIT. Registers: state, cnt[CNT_W], ret_state.
- Outputs are combinational from state and inputs (zero-latency stall).
- DATA_MEM_BUSYWAIT has priority in every state:
  - STALL_ALL=1, STALL_FRONT=0, BUBBLE_S3=0.
  - cnt is frozen.
  - Next state is MEM_WAIT; ret_state captures the state that would otherwise have been entered.
- IDLE, no busywait:
  - H=1: STALL_FRONT=1, BUBBLE_S3=1 this cycle.
  - If STALL_CYCLES==1, stay in IDLE.
  - Otherwise go to LU_STALL with cnt=STALL_CYCLES-1.
  - H=0: all outputs 0.
- LU_STALL, no busywait:
  - STALL_FRONT=1, BUBBLE_S3=1.
  - cnt decrements; when cnt==1 the next state is IDLE.
  - H is ignored here; the bubble already separates the load.
- MEM_WAIT:
  - While busywait stays high: STALL_ALL=1 and the block holds state.
  - On the first cycle busywait is low: outputs follow ret_state's rules that cycle, and the transition is taken from ret_state.
  - An IDLE→LU_STALL entry blocked by busywait resumes correctly, and the hazard is not double-counted.
- Reset (RESET=0, async):
  - state=IDLE, cnt=0, ret_state=IDLE.
  - All outputs forced 0 while reset is held.
  - Release is synchronous to the next CLK edge; nothing after release depends on pre-reset state.
- Mid-stall reset aborts the penalty; there is no residual stall after release.
- STALL_FRONT and STALL_ALL are never both 1. BUBBLE_S3 implies STALL_FRONT.

Optional Feature:
HAZARD_PERF_EN:
- Defined: adds outputs LU_STALL_COUNT[15:0] and MEM_WAIT_COUNT[15:0].
  - LU_STALL_COUNT increments each cycle BUBBLE_S3=1.
  - MEM_WAIT_COUNT increments each cycle STALL_ALL=1.
  - Both saturate at 16'hFFFF and reset to 0.
  - Input PERF_CLR (sync, active-high) zeroes both; clear wins over increment.
- Undefined: ports and counters are absent; stall behaviour is identical.

Test Plan:
1. STALL_CYCLES=1; S3 load rd=5; S2 add rs1=5 -> STALL_FRONT=1, BUBBLE_S3=1 for exactly 1 cycle; next cycle, with S3 a bubble, all outputs 0.
2. S3 load rd=5; S2 store rs1=2, rs2=5, S2_MEM_WRITE=1 -> no stall. Repeat with rs1=5 -> 1-cycle stall.
3. S3 load rd=0; S2 uses rs1=0 and rs2=0 -> no stall.
4. STALL_CYCLES=3; hazard at cycle 0 -> STALL_FRONT/BUBBLE_S3 high on cycles 0,1,2 and low on cycle 3. Busywait high during cycle 1 for 4 cycles -> STALL_ALL=1 for 4 cycles, stall resumes with 2 penalty cycles left, total STALL_FRONT cycles = 3.
5. Busywait held 10 cycles from IDLE -> STALL_ALL=1 for exactly 10 cycles, other outputs 0. With HAZARD_PERF_EN, MEM_WAIT_COUNT=10.
6. RESET driven low during LU_STALL (STALL_CYCLES=4, cycle 1) -> outputs 0 immediately. After release with no hazard, outputs stay 0; with HAZARD_PERF_EN, counters read 0.
